// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: FSM state encoding, the
// terminating instruction and the byte/word geometry.
package program_loader_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_BYTE_DEF = 8;

   localparam logic [NB_DATA_DEF-1:0] HALT_WORD      = 32'hFFFF_FFFF;
   localparam int                     BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

   typedef enum logic [1:0] {
      LOADER_IDLE = 2'd0,
      LOADER_LOAD = 2'd1,
      LOADER_DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler. o_word/o_word_valid are combinational on
// the cycle the last byte of a word arrives so the caller can register the write.
module word_assembler
   import program_loader_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_BYTE = NB_BYTE_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_byte_valid,
   input  logic [NB_BYTE-1:0] i_byte,
   output logic [NB_DATA-1:0] o_word,
   output logic               o_word_valid
);

   localparam int NBYTES = NB_DATA / NB_BYTE;
   localparam int NB_IDX = $clog2(NBYTES);
   localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NBYTES - 1);

   // Holds the earlier bytes of the word in flight, oldest in the top bits.
   logic [NB_DATA-NB_BYTE-1:0] shift_q;
   logic [NB_IDX-1:0]          idx_q;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else if (i_byte_valid) begin
         shift_q <= {shift_q[NB_DATA-2*NB_BYTE-1:0], i_byte};
         idx_q   <= idx_q + 1'b1;
      end
   end

   assign o_word       = {shift_q, i_byte};
   assign o_word_valid = i_byte_valid && (idx_q == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Loads instruction memory from the debug byte stream, stopping on HALT or a
// full memory, and gates CPU fetch reads off the shared read port while loading.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int                  NB_DATA      = NB_DATA_DEF,
   parameter int                  NB_BYTE      = NB_BYTE_DEF,
   parameter int                  NB_ADDR      = 6,
   parameter int                  MEMORY_DEPTH = 64,
   parameter logic [NB_DATA-1:0]  HALT_WORD    = program_loader_pkg::HALT_WORD
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_rx_valid,
   input  logic               i_cpu_read_enable,
   input  logic [NB_ADDR-1:0] i_cpu_read_addr,
   output logic [NB_ADDR-1:0] o_mem_write_addr,
   output logic [NB_DATA-1:0] o_mem_write_data,
   output logic               o_mem_write_enable,
   output logic [NB_ADDR-1:0] o_mem_read_addr,
   output logic               o_mem_read_enable,
   output logic               o_loading,
   output logic               o_done,
   output logic               o_overflow,
   output logic [NB_ADDR:0]   o_word_count
);

   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);
   localparam logic [NB_ADDR:0]   MAX_COUNT = (NB_ADDR+1)'(MEMORY_DEPTH);

   loader_state_t      state_q, state_d;
   logic [NB_ADDR-1:0] write_addr_q;
   logic [NB_DATA-1:0] word;
   logic               word_valid;
   logic               accept, start_load, last_addr, is_halt;

   assign accept     = (state_q == LOADER_LOAD) && i_rx_valid;
   assign start_load = i_start && (state_q != LOADER_LOAD);
   assign last_addr  = (write_addr_q == LAST_ADDR);
   assign is_halt    = (word == HALT_WORD);

   word_assembler #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_word_assembler (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_clear      (start_load),
      .i_byte_valid (accept),
      .i_byte       (i_rx_data),
      .o_word       (word),
      .o_word_valid (word_valid)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOADER_IDLE, LOADER_DONE:
            if (i_start) state_d = LOADER_LOAD;
         LOADER_LOAD:
            if (word_valid && (is_halt || last_addr)) state_d = LOADER_DONE;
         default:
            state_d = LOADER_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q            <= LOADER_IDLE;
         write_addr_q       <= '0;
         o_word_count       <= '0;
         o_overflow         <= 1'b0;
         o_mem_write_enable <= 1'b0;
         o_mem_write_addr   <= '0;
         o_mem_write_data   <= '0;
      end else begin
         state_q            <= state_d;
         o_mem_write_enable <= 1'b0;
         if (start_load) begin
            write_addr_q <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
         end else if (word_valid) begin
            o_mem_write_enable <= 1'b1;
            o_mem_write_addr   <= write_addr_q;
            o_mem_write_data   <= word;
            // The load ends on the last address, so holding it avoids a wrap.
            if (!last_addr) write_addr_q <= write_addr_q + 1'b1;
            if (o_word_count != MAX_COUNT) o_word_count <= o_word_count + 1'b1;
            if (last_addr && !is_halt) o_overflow <= 1'b1;
         end
      end
   end

   assign o_loading         = (state_q == LOADER_LOAD);
   assign o_done            = (state_q == LOADER_DONE);
   assign o_mem_read_addr   = i_cpu_read_addr;
   assign o_mem_read_enable = i_cpu_read_enable && !o_loading;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, hand-written corner
// sequences and randomized traffic against a byte-queue reference model.
module tb_program_loader;

   localparam int          NB_ADDR = 6;
   localparam int          DEPTH   = 64;
   localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

   logic               i_clock = 1'b0;
   logic               i_reset, i_start, i_rx_valid, i_cpu_read_enable;
   logic [7:0]         i_rx_data;
   logic [NB_ADDR-1:0] i_cpu_read_addr;
   logic [NB_ADDR-1:0] o_mem_write_addr, o_mem_read_addr;
   logic [31:0]        o_mem_write_data;
   logic               o_mem_write_enable, o_mem_read_enable, o_loading, o_done, o_overflow;
   logic [NB_ADDR:0]   o_word_count;

   program_loader #(
      .NB_DATA(32), .NB_BYTE(8), .NB_ADDR(NB_ADDR), .MEMORY_DEPTH(DEPTH), .HALT_WORD(HALT)
   ) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .i_cpu_read_enable(i_cpu_read_enable), .i_cpu_read_addr(i_cpu_read_addr),
      .o_mem_write_addr(o_mem_write_addr), .o_mem_write_data(o_mem_write_data),
      .o_mem_write_enable(o_mem_write_enable), .o_mem_read_addr(o_mem_read_addr),
      .o_mem_read_enable(o_mem_read_enable), .o_loading(o_loading), .o_done(o_done),
      .o_overflow(o_overflow), .o_word_count(o_word_count)
   );

   always #5 i_clock = ~i_clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: bytes of the word in flight kept in a queue.
   bit          m_load, m_done, m_ovf, m_we;
   int          m_addr, m_count;
   logic [31:0] m_wdata;
   int          m_waddr;
   logic [7:0]  m_bytes[$];

   task automatic model_edge(input bit rst, input bit start, input bit rxv, input logic [7:0] rxd);
      logic [31:0] w;
      if (rst) begin
         m_load = 0; m_done = 0; m_ovf = 0; m_we = 0;
         m_addr = 0; m_count = 0; m_wdata = '0; m_waddr = 0;
         m_bytes.delete();
      end else begin
         m_we = 0;
         if (!m_load && start) begin
            m_load = 1; m_done = 0; m_ovf = 0;
            m_addr = 0; m_count = 0;
            m_bytes.delete();
         end else if (m_load && rxv) begin
            m_bytes.push_back(rxd);
            if (m_bytes.size() == 4) begin
               w = 0;
               foreach (m_bytes[k]) w = w * 256 + 32'(m_bytes[k]);
               m_bytes.delete();
               m_we = 1; m_waddr = m_addr; m_wdata = w;
               if (w == HALT || m_addr == DEPTH - 1) begin
                  m_load = 0; m_done = 1;
                  if (w != HALT) m_ovf = 1;
               end
               m_addr++;
               if (m_count < DEPTH) m_count++;
            end
         end
      end
   endtask

   task automatic step(input bit rst, input bit start, input bit rxv, input logic [7:0] rxd,
                       input bit rde, input logic [NB_ADDR-1:0] rda);
      i_reset = rst; i_start = start; i_rx_valid = rxv; i_rx_data = rxd;
      i_cpu_read_enable = rde; i_cpu_read_addr = rda;
      @(posedge i_clock);
      model_edge(rst, start, rxv, rxd);
      #1;
      chk("m_we", 64'(o_mem_write_enable), 64'(m_we));
      chk("m_loading", 64'(o_loading), 64'(m_load));
      chk("m_done", 64'(o_done), 64'(m_done));
      chk("m_overflow", 64'(o_overflow), 64'(m_ovf));
      chk("m_count", 64'(o_word_count), 64'(m_count));
      chk("m_rd_en", 64'(o_mem_read_enable), 64'(rde && !m_load));
      chk("m_rd_addr", 64'(o_mem_read_addr), 64'(rda));
      if (m_we || rst) begin
         chk("m_waddr", 64'(o_mem_write_addr), 64'(m_waddr));
         chk("m_wdata", 64'(o_mem_write_data), 64'(m_wdata));
      end
   endtask

   task automatic idle_step();
      step(0, 0, 0, 8'h00, 1'($urandom_range(0, 1)), 6'($urandom));
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int b = 3; b >= 0; b--) begin
         if ($urandom_range(0, 2) == 0) idle_step();
         step(0, 0, 1, w[8*b +: 8], 1'($urandom_range(0, 1)), 6'($urandom));
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      w[31:24] = 8'($urandom_range(0, 254));
      return w;
   endfunction

   typedef struct {
      bit          start, rxv;
      logic [7:0]  rxd;
      bit          rde;
      bit          we;
      logic [5:0]  waddr;
      logic [31:0] wdata;
      bit          load, done;
      int          cnt;
      bit          rden;
   } vec_t;

   function automatic vec_t v(bit s, bit rv, logic [7:0] d, bit re, bit we, logic [5:0] wa,
                              logic [31:0] wd, bit ld, bit dn, int c, bit rden);
      vec_t r;
      r.start = s; r.rxv = rv; r.rxd = d; r.rde = re; r.we = we; r.waddr = wa;
      r.wdata = wd; r.load = ld; r.done = dn; r.cnt = c; r.rden = rden;
      return r;
   endfunction

   vec_t tbl[21];

   initial begin
      //             st rv data  re we wa  wdata         ld dn cnt rden
      tbl[0]  = v(0, 1, 8'hAA, 1, 0, 0, 32'h0,        0, 0, 0, 1);
      tbl[1]  = v(1, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 0, 0);
      tbl[2]  = v(0, 1, 8'h01, 0, 0, 0, 32'h0,        1, 0, 0, 0);
      tbl[3]  = v(0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 0, 0, 0);
      tbl[4]  = v(0, 1, 8'h03, 0, 0, 0, 32'h0,        1, 0, 0, 0);
      tbl[5]  = v(0, 1, 8'h04, 0, 1, 0, 32'h01020304, 1, 0, 1, 0);
      tbl[6]  = v(1, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 1, 0);
      tbl[7]  = v(0, 1, 8'h11, 0, 0, 0, 32'h0,        1, 0, 1, 0);
      tbl[8]  = v(0, 1, 8'h22, 0, 0, 0, 32'h0,        1, 0, 1, 0);
      tbl[9]  = v(0, 1, 8'h33, 0, 0, 0, 32'h0,        1, 0, 1, 0);
      tbl[10] = v(0, 1, 8'h44, 0, 1, 1, 32'h11223344, 1, 0, 2, 0);
      tbl[11] = v(0, 1, 8'h55, 0, 0, 0, 32'h0,        1, 0, 2, 0);
      tbl[12] = v(0, 1, 8'h66, 0, 0, 0, 32'h0,        1, 0, 2, 0);
      tbl[13] = v(0, 1, 8'h77, 0, 0, 0, 32'h0,        1, 0, 2, 0);
      tbl[14] = v(0, 1, 8'h88, 0, 1, 2, 32'h55667788, 1, 0, 3, 0);
      tbl[15] = v(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 3, 0);
      tbl[16] = v(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 3, 0);
      tbl[17] = v(0, 1, 8'hFF, 0, 0, 0, 32'h0,        1, 0, 3, 0);
      tbl[18] = v(0, 1, 8'hFF, 0, 1, 3, 32'hFFFFFFFF, 0, 1, 4, 0);
      tbl[19] = v(0, 0, 8'h00, 1, 0, 0, 32'h0,        0, 1, 4, 1);
      tbl[20] = v(0, 1, 8'h55, 0, 0, 0, 32'h0,        0, 1, 4, 0);

      i_reset = 1; i_start = 0; i_rx_valid = 0; i_rx_data = '0;
      i_cpu_read_enable = 0; i_cpu_read_addr = '0;
      step(1, 0, 0, 8'h00, 0, 6'd0);
      step(1, 0, 0, 8'h00, 0, 6'd0);
      chk("rst_we", 64'(o_mem_write_enable), 64'd0);
      chk("rst_loading", 64'(o_loading), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_count", 64'(o_word_count), 64'd0);
      chk("rst_waddr", 64'(o_mem_write_addr), 64'd0);
      chk("rst_wdata", 64'(o_mem_write_data), 64'd0);

      // Directed table
      for (int i = 0; i < 21; i++) begin
         step(0, tbl[i].start, tbl[i].rxv, tbl[i].rxd, tbl[i].rde, 6'd5);
         chk($sformatf("tbl%0d_we", i), 64'(o_mem_write_enable), 64'(tbl[i].we));
         chk($sformatf("tbl%0d_loading", i), 64'(o_loading), 64'(tbl[i].load));
         chk($sformatf("tbl%0d_done", i), 64'(o_done), 64'(tbl[i].done));
         chk($sformatf("tbl%0d_count", i), 64'(o_word_count), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_rden", i), 64'(o_mem_read_enable), 64'(tbl[i].rden));
         chk($sformatf("tbl%0d_rdaddr", i), 64'(o_mem_read_addr), 64'd5);
         chk($sformatf("tbl%0d_ovf", i), 64'(o_overflow), 64'd0);
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d_waddr", i), 64'(o_mem_write_addr), 64'(tbl[i].waddr));
            chk($sformatf("tbl%0d_wdata", i), 64'(o_mem_write_data), 64'(tbl[i].wdata));
         end
      end

      // Restart from DONE, then fill memory without a HALT word
      step(0, 1, 0, 8'h00, 0, 6'd0);
      for (int w = 0; w < DEPTH; w++) send_word(rand_word());
      chk("full_we", 64'(o_mem_write_enable), 64'd1);
      chk("full_waddr", 64'(o_mem_write_addr), 64'd63);
      chk("full_done", 64'(o_done), 64'd1);
      chk("full_ovf", 64'(o_overflow), 64'd1);
      chk("full_count", 64'(o_word_count), 64'd64);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 8'h12, 0, 6'd0);
      chk("full_extra_we", 64'(o_mem_write_enable), 64'd0);
      chk("full_extra_ovf", 64'(o_overflow), 64'd1);

      // Restart from DONE clears overflow; HALT lands exactly on the last address
      step(0, 1, 0, 8'h00, 0, 6'd0);
      chk("restart_ovf", 64'(o_overflow), 64'd0);
      chk("restart_count", 64'(o_word_count), 64'd0);
      send_word(32'hCAFE_0001);
      chk("restart_waddr", 64'(o_mem_write_addr), 64'd0);
      for (int w = 1; w < DEPTH - 1; w++) send_word(rand_word());
      send_word(HALT);
      chk("halt_last_waddr", 64'(o_mem_write_addr), 64'd63);
      chk("halt_last_done", 64'(o_done), 64'd1);
      chk("halt_last_ovf", 64'(o_overflow), 64'd0);
      chk("halt_last_count", 64'(o_word_count), 64'd64);

      // Reset mid-word: partial bytes never reach memory
      step(0, 1, 0, 8'h00, 0, 6'd0);
      send_word(32'h0A0B_0C0D);
      step(0, 0, 1, 8'hDE, 0, 6'd0);
      step(0, 0, 1, 8'hAD, 0, 6'd0);
      step(1, 0, 1, 8'hBE, 0, 6'd0);
      chk("midrst_we", 64'(o_mem_write_enable), 64'd0);
      chk("midrst_loading", 64'(o_loading), 64'd0);
      chk("midrst_count", 64'(o_word_count), 64'd0);
      step(0, 0, 1, 8'hEF, 0, 6'd0);
      chk("midrst_idle_we", 64'(o_mem_write_enable), 64'd0);
      step(0, 1, 0, 8'h00, 0, 6'd0);
      send_word(32'h1357_9BDF);
      chk("midrst_reload_waddr", 64'(o_mem_write_addr), 64'd0);
      chk("midrst_reload_wdata", 64'(o_mem_write_data), 64'h13579BDF);
      chk("midrst_reload_count", 64'(o_word_count), 64'd1);

      // Randomized traffic; words are often all-FF to hit HALT frequently
      begin
         bit halt_mode;
         int nbyte;
         halt_mode = 0; nbyte = 0;
         for (int c = 0; c < 5000; c++) begin
            bit rst, st, rv;
            logic [7:0] d;
            rst = ($urandom_range(0, 699) == 0);
            st  = ($urandom_range(0, 29) == 0);
            rv  = 1'($urandom_range(0, 1));
            if (rv && nbyte == 0) halt_mode = ($urandom_range(0, 2) == 0);
            d = halt_mode ? 8'hFF : 8'($urandom);
            if (rv) nbyte = (nbyte + 1) % 4;
            step(rst, st, rv, d, 1'($urandom_range(0, 1)), 6'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sequences loading of the instruction memory from the debug byte stream (UART receiver) before execution.
- Assembles 8-bit bytes into 32-bit instruction words and drives the memory write port with an auto-incrementing address.
- Stops when the HALT word is loaded or memory is full.
- Shares the memory read port: blocks CPU fetch reads while loading and passes them through otherwise.

Parameters:
- NB_DATA, 32, instruction/memory word width.
- NB_BYTE, 8, width of received byte.
- NB_ADDR, 6, memory address width.
- MEMORY_DEPTH, 64, number of memory words.
- HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is written to memory before stopping.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a load.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  i_rx_data valid this cycle (one-cycle pulse per byte).
- i_cpu_read_enable  in  1  fetch read request.
- i_cpu_read_addr  in  NB_ADDR  fetch address.
- o_mem_write_addr  out  NB_ADDR  memory write address.
- o_mem_write_data  out  NB_DATA  memory write data.
- o_mem_write_enable  out  1  memory write strobe.
- o_mem_read_addr  out  NB_ADDR  memory read address.
- o_mem_read_enable  out  1  memory read enable.
- o_loading  out  1  high while in LOAD.
- o_done  out  1  high while in DONE.
- o_overflow  out  1  memory filled without a HALT word; sticky until the next i_start or reset.
- o_word_count  out  NB_ADDR+1  words written in the current or last load.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: state IDLE; all registered outputs 0; byte index 0; write address 0; word count 0.
- Reset applied mid-load aborts immediately. Memory contents already written are left as-is.
- States: IDLE, LOAD, DONE.
  - IDLE -> LOAD on i_start. Clears the byte index, write address, word count and o_overflow.
  - LOAD -> DONE on the cycle the final write is issued: either the assembled word equals HALT_WORD, or the write address is MEMORY_DEPTH-1.
  - DONE -> LOAD on i_start, with the same clearing as from IDLE.
  - i_start in LOAD is ignored.
- Byte assembly:
  - Accepted only in LOAD on i_rx_valid. Bytes on i_rx_valid in IDLE or DONE are dropped.
  - The first byte of each word is the MSB (big-endian): byte k goes to bits [NB_DATA-1-8k -: 8].
  - The byte index is 2 bits and wraps 3 -> 0 on the 4th byte.
- Write timing:
  - The 4th byte is accepted at cycle N. At N+1, o_mem_write_enable=1 for exactly one cycle, with o_mem_write_addr = current address and o_mem_write_data = assembled word.
  - The address increments and o_word_count increments at N+1.
  - There is no write at any other time.
  - A byte accepted at N+1 becomes byte 0 of the next word; no byte is lost.
- Termination:
  - The state becomes DONE at N+1, so o_done=1 from N+1, concurrent with the final write strobe.
  - HALT_WORD is written, then the load stops.
  - If address MEMORY_DEPTH-1 is written with a non-HALT word, o_overflow=1 from N+1.
  - If the final word is HALT_WORD at address MEMORY_DEPTH-1, o_overflow stays 0.
- Partial word: if a reset or abort occurs with fewer than 4 bytes received, nothing is written.
- Read-port sharing:
  - o_mem_read_addr = i_cpu_read_addr, combinational.
  - o_mem_read_enable = i_cpu_read_enable & ~o_loading.
  - During LOAD, fetch reads are suppressed, so the memory output register holds its last value.
- Width rules: o_word_count saturates at MEMORY_DEPTH. The address never wraps within one load.

Decomposition:
- Shared package holds:
  - state encoding constants LOADER_IDLE=2'd0, LOADER_LOAD=2'd1, LOADER_DONE=2'd2;
  - HALT_WORD;
  - BYTES_PER_WORD = NB_DATA/NB_BYTE.
- One natural sub-module, word_assembler: byte shift register plus index counter, producing o_word and a o_word_valid pulse.
- The FSM, address counter and read gating stay in program_loader.

Test Plan:
- Reset, then i_start, then bytes 01 02 03 04 → one write at addr 0, data 32'h01020304, one cycle after the 4th byte; o_word_count=1; o_loading=1.
- Bytes for 3 words, then FF FF FF FF → writes at addr 0..3, the last with data FFFFFFFF; o_done=1 on that cycle; o_word_count=4; o_overflow=0.
- 256 non-HALT bytes (64 words) → 64 writes at addr 0..63; o_done=1 and o_overflow=1 at the 64th write; a further byte produces no write.
- i_cpu_read_enable=1 with addr 5 during LOAD → o_mem_read_enable=0 and o_mem_read_addr=5. The same request in DONE → o_mem_read_enable=1.
- Reset after 2 bytes of word 1 (one word already written) → no write, all outputs 0, state IDLE. A new i_start plus 4 bytes writes at addr 0.
- Bytes sent while IDLE → no write. i_start during LOAD → address not cleared. i_start in DONE → o_overflow cleared, load restarts at addr 0.
